// File: rtl/alu_operand_stack_pkg.sv
// Shared types for the ALU operand stack: data width,
// command and controller state encodings.
package alu_operand_stack_pkg;

   localparam int ALU_W = 8;

   typedef enum logic [1:0] {
      CMD_NOP    = 2'b00,
      CMD_PUSH   = 2'b01,
      CMD_POP    = 2'b10,
      CMD_REDUCE = 2'b11
   } cmd_e;

   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_WAIT_ALU = 1'b1
   } state_e;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/alu_operand_stack_stack_bank.sv
// NSTACK x DEPTH operand storage with per-stack depth counters,
// one write port and top/second read ports on the selected stack.
module stack_bank
   import alu_operand_stack_pkg::*;
#(
   parameter int NSTACK = 4,
   parameter int DEPTH  = 8,
   parameter int W      = ALU_W,
   localparam int SW    = idx_w(NSTACK),
   localparam int AW    = idx_w(DEPTH),
   localparam int DW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [SW-1:0] rd_sel,
   output logic [W-1:0]  rd_top,
   output logic [W-1:0]  rd_sec,
   output logic [DW-1:0] rd_depth,
   input  logic          wr_en,
   input  logic [SW-1:0] wr_sel,
   input  logic [AW-1:0] wr_addr,
   input  logic [W-1:0]  wr_data,
   input  logic          dp_en,
   input  logic [SW-1:0] dp_sel,
   input  logic [DW-1:0] dp_val
);

   logic [W-1:0]  mem [NSTACK][DEPTH];
   logic [DW-1:0] cnt [NSTACK];
   logic [AW-1:0] a_top;
   logic [AW-1:0] a_sec;

   // storage is deliberately left uninitialised by reset
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_sel][wr_addr] <= wr_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NSTACK; i++) cnt[i] <= '0;
      end else if (dp_en) begin
         cnt[dp_sel] <= dp_val;
      end
   end

   assign rd_depth = cnt[rd_sel];
   assign a_top    = AW'(rd_depth - DW'(1));
   assign a_sec    = AW'(rd_depth - DW'(2));
   assign rd_top   = (rd_depth == '0) ? '0 : mem[rd_sel][a_top];
   assign rd_sec   = mem[rd_sel][a_sec];

endmodule

// File: rtl/alu_operand_stack.sv
// Operand stack controller: PUSH/POP/REDUCE command handshake,
// ALU request/ack sequencing and sticky error flags.
module alu_operand_stack
   import alu_operand_stack_pkg::*;
#(
   parameter int NSTACK = 4,
   parameter int DEPTH  = 8,
   parameter int W      = ALU_W,
   localparam int SW    = idx_w(NSTACK),
   localparam int AW    = idx_w(DEPTH),
   localparam int DW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [1:0]    cmd,
   input  logic [SW-1:0] sel,
   input  logic [W-1:0]  push_data,
   output logic          alu_req,
   output logic [W-1:0]  alu_a,
   output logic [W-1:0]  alu_b,
   input  logic          alu_ack,
   input  logic [W-1:0]  alu_result,
   output logic [W-1:0]  top,
   output logic [DW-1:0] depth,
   output logic          full,
   output logic          empty,
   output logic          err_ovf,
   output logic          err_unf
);

   state_e        state_q, state_d;
   logic [SW-1:0] k_q, k_d;
   logic [DW-1:0] dk_q, dk_d;
   logic [W-1:0]  a_q, a_d, b_q, b_d;
   logic          ovf_q, ovf_d, unf_q, unf_d;
   logic [W-1:0]  sec;
   logic          wr_en, dp_en;
   logic [SW-1:0] wr_sel, dp_sel;
   logic [AW-1:0] wr_addr;
   logic [W-1:0]  wr_data;
   logic [DW-1:0] dp_val;
   cmd_e          op;

   stack_bank #(
      .NSTACK (NSTACK),
      .DEPTH  (DEPTH),
      .W      (W)
   ) u_bank (
      .clk      (clk),
      .rst      (rst),
      .rd_sel   (sel),
      .rd_top   (top),
      .rd_sec   (sec),
      .rd_depth (depth),
      .wr_en    (wr_en),
      .wr_sel   (wr_sel),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .dp_en    (dp_en),
      .dp_sel   (dp_sel),
      .dp_val   (dp_val)
   );

   assign op        = cmd_e'(cmd);
   assign full      = (depth == DW'(DEPTH));
   assign empty     = (depth == '0);
   assign cmd_ready = (state_q == ST_IDLE);
   assign alu_req   = (state_q == ST_WAIT_ALU);
   assign alu_a     = a_q;
   assign alu_b     = b_q;
   assign err_ovf   = ovf_q;
   assign err_unf   = unf_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         k_q     <= '0;
         dk_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         dk_q    <= dk_d;
         a_q     <= a_d;
         b_q     <= b_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      dk_d    = dk_q;
      a_d     = a_q;
      b_d     = b_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      wr_en   = 1'b0;
      wr_sel  = sel;
      wr_addr = AW'(depth);
      wr_data = push_data;
      dp_en   = 1'b0;
      dp_sel  = sel;
      dp_val  = depth;
      unique case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               unique case (op)
                  CMD_PUSH: begin
                     if (full) begin
                        ovf_d = 1'b1;
                     end else begin
                        wr_en  = 1'b1;
                        dp_en  = 1'b1;
                        dp_val = depth + DW'(1);
                     end
                  end
                  CMD_POP: begin
                     if (empty) begin
                        unf_d = 1'b1;
                     end else begin
                        dp_en  = 1'b1;
                        dp_val = depth - DW'(1);
                     end
                  end
                  CMD_REDUCE: begin
                     if (depth < DW'(2)) begin
                        unf_d = 1'b1;
                     end else begin
                        state_d = ST_WAIT_ALU;
                        k_d     = sel;
                        dk_d    = depth;
                        a_d     = top;
                        b_d     = sec;
                     end
                  end
                  default: ;
               endcase
            end
         end
         ST_WAIT_ALU: begin
            // result replaces the two operands: write at old depth-2
            if (alu_ack) begin
               wr_en   = 1'b1;
               wr_sel  = k_q;
               wr_addr = AW'(dk_q - DW'(2));
               wr_data = alu_result;
               dp_en   = 1'b1;
               dp_sel  = k_q;
               dp_val  = dk_q - DW'(1);
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_alu_operand_stack.sv
// Scoreboard bench for alu_operand_stack: a reference stack model
// predicts status and ALU operands for directed and random traffic.
module tb_alu_operand_stack;
   import alu_operand_stack_pkg::*;

   localparam int NS = 4;
   localparam int DP = 8;
   localparam int W  = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         cmd_valid;
   logic         cmd_ready;
   logic [1:0]   cmd;
   logic [1:0]   sel;
   logic [W-1:0] push_data;
   logic         alu_req;
   logic [W-1:0] alu_a;
   logic [W-1:0] alu_b;
   logic         alu_ack;
   logic [W-1:0] alu_result;
   logic [W-1:0] top;
   logic [3:0]   depth;
   logic         full;
   logic         empty;
   logic         err_ovf;
   logic         err_unf;

   int total = 0;
   int bad   = 0;

   int           m_dep [NS];
   logic [W-1:0] m_mem [NS][DP];
   logic         m_ovf;
   logic         m_unf;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
   } ops_t;
   ops_t sb_q[$];

   alu_operand_stack #(.NSTACK(NS), .DEPTH(DP), .W(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd        (cmd),
      .sel        (sel),
      .push_data  (push_data),
      .alu_req    (alu_req),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_ack    (alu_ack),
      .alu_result (alu_result),
      .top        (top),
      .depth      (depth),
      .full       (full),
      .empty      (empty),
      .err_ovf    (err_ovf),
      .err_unf    (err_unf)
   );

   always #5 clk = ~clk;

   function automatic logic [13:0] stat_exp(input int s);
      logic [7:0] t;
      t = (m_dep[s] == 0) ? 8'h00 : m_mem[s][m_dep[s]-1];
      return {t, 4'(m_dep[s]), m_dep[s] == DP, m_dep[s] == 0};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NS; i++) m_dep[i] = 0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endtask

   // drive one command in IDLE; model predicts the outcome
   task automatic do_cmd(input logic [1:0] c, input int s,
                         input logic [W-1:0] d, output bit acc);
      acc       = 1'b0;
      cmd_valid = 1'b1;
      cmd       = c;
      sel       = 2'(s);
      push_data = d;
      case (c)
         2'b01: if (m_dep[s] == DP) m_ovf = 1'b1;
                else begin m_mem[s][m_dep[s]] = d; m_dep[s]++; end
         2'b10: if (m_dep[s] == 0) m_unf = 1'b1;
                else m_dep[s]--;
         2'b11: if (m_dep[s] < 2) m_unf = 1'b1;
                else begin
                   acc = 1'b1;
                   sb_q.push_back('{a: m_mem[s][m_dep[s]-1],
                                    b: m_mem[s][m_dep[s]-2]});
                end
         default: ;
      endcase
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      cmd       = 2'b00;
   endtask

   task automatic do_ack(input int s, input logic [W-1:0] r);
      alu_ack    = 1'b1;
      alu_result = r;
      @(posedge clk); #1;
      alu_ack = 1'b0;
      m_dep[s]--;
      m_mem[s][m_dep[s]-1] = r;
   endtask

   task automatic test_reset();
      rst = 1'b1; cmd_valid = 1'b0; cmd = 2'b00; sel = 2'd0;
      push_data = '0; alu_ack = 1'b0; alu_result = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({cmd_ready, alu_req} !== 2'b10) begin
         bad++;
         $display("FAIL reset_hs got=%b exp=10", {cmd_ready, alu_req});
      end
      total++;
      if ({alu_a, alu_b} !== 16'h0) begin
         bad++;
         $display("FAIL reset_ops got=%h exp=0000", {alu_a, alu_b});
      end
      rst = 1'b0;
      for (int s = 0; s < NS; s++) begin
         sel = 2'(s); #1;
         total++;
         if ({top, depth, full, empty} !== stat_exp(s)) begin
            bad++;
            $display("FAIL reset_stat k=%0d got=%h exp=%h", s,
                     {top, depth, full, empty}, stat_exp(s));
         end
      end
      total++;
      if ({err_ovf, err_unf} !== 2'b00) begin
         bad++;
         $display("FAIL reset_err got=%b exp=00", {err_ovf, err_unf});
      end
   endtask

   task automatic test_push();
      bit acc;
      do_cmd(2'b01, 1, 8'h05, acc);
      do_cmd(2'b01, 1, 8'h03, acc);
      for (int s = 0; s < 2; s++) begin
         sel = 2'(s); #1;
         total++;
         if ({top, depth, full, empty} !== stat_exp(s)) begin
            bad++;
            $display("FAIL push_stat k=%0d got=%h exp=%h", s,
                     {top, depth, full, empty}, stat_exp(s));
         end
      end
   endtask

   task automatic wait_ops(input string tag, output ops_t got);
      ops_t e;
      got = '{a: '0, b: '0};
      for (int i = 0; i < 8 && !alu_req; i++) begin
         @(posedge clk); #1;
      end
      total++;
      if (!alu_req || sb_q.size() == 0) begin
         bad++;
         $display("FAIL %s_req got=%b exp=1", tag, alu_req);
         if (sb_q.size() != 0) void'(sb_q.pop_front());
      end else begin
         e   = sb_q.pop_front();
         got = e;
         if ({alu_a, alu_b} !== {e.a, e.b}) begin
            bad++;
            $display("FAIL %s_ops got=%h exp=%h", tag,
                     {alu_a, alu_b}, {e.a, e.b});
         end
      end
   endtask

   task automatic test_reduce();
      bit   acc;
      ops_t e;
      do_cmd(2'b11, 1, 8'h00, acc);
      wait_ops("reduce", e);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         total++;
         if ({alu_req, cmd_ready, alu_a, alu_b} !== {2'b10, e.a, e.b}) begin
            bad++;
            $display("FAIL reduce_hold cyc=%0d got=%h exp=%h", i,
                     {alu_req, cmd_ready, alu_a, alu_b},
                     {2'b10, e.a, e.b});
         end
      end
      do_ack(1, 8'h08);
      sel = 2'd1; #1;
      total++;
      if ({alu_req, cmd_ready} !== 2'b01) begin
         bad++;
         $display("FAIL reduce_done got=%b exp=01", {alu_req, cmd_ready});
      end
      total++;
      if ({top, depth, full, empty} !== stat_exp(1)) begin
         bad++;
         $display("FAIL reduce_stat got=%h exp=%h",
                  {top, depth, full, empty}, stat_exp(1));
      end
   endtask

   task automatic test_overflow();
      bit acc;
      for (int i = 0; i < 9; i++) begin
         do_cmd(2'b01, 2, 8'(8'h10 + i), acc);
         if (i == 7) begin
            total++;
            if (err_ovf !== 1'b0) begin
               bad++;
               $display("FAIL ovf_early got=%b exp=0", err_ovf);
            end
         end
      end
      sel = 2'd2; #1;
      total++;
      if ({top, depth, full, empty} !== stat_exp(2)) begin
         bad++;
         $display("FAIL ovf_stat got=%h exp=%h",
                  {top, depth, full, empty}, stat_exp(2));
      end
      total++;
      if ({err_ovf, err_unf} !== {m_ovf, m_unf}) begin
         bad++;
         $display("FAIL ovf_err got=%b exp=%b",
                  {err_ovf, err_unf}, {m_ovf, m_unf});
      end
   endtask

   task automatic test_underflow();
      bit acc;
      do_cmd(2'b01, 3, 8'h21, acc);
      do_cmd(2'b11, 3, 8'h00, acc);
      sel = 2'd3; #1;
      total++;
      if ({alu_req, cmd_ready} !== 2'b01) begin
         bad++;
         $display("FAIL unf_hs got=%b exp=01", {alu_req, cmd_ready});
      end
      total++;
      if ({top, depth, full, empty} !== stat_exp(3)) begin
         bad++;
         $display("FAIL unf_stat got=%h exp=%h",
                  {top, depth, full, empty}, stat_exp(3));
      end
      total++;
      if ({err_ovf, err_unf} !== {m_ovf, m_unf}) begin
         bad++;
         $display("FAIL unf_err got=%b exp=%b",
                  {err_ovf, err_unf}, {m_ovf, m_unf});
      end
   endtask

   task automatic test_wait_alu();
      bit   acc;
      ops_t e;
      do_cmd(2'b01, 0, 8'h40, acc);
      do_cmd(2'b01, 0, 8'h41, acc);
      do_cmd(2'b11, 0, 8'h00, acc);
      wait_ops("wait", e);
      cmd_valid = 1'b1; cmd = 2'b01; sel = 2'd0; push_data = 8'h77;
      #1;
      total++;
      if (cmd_ready !== 1'b0) begin
         bad++;
         $display("FAIL wait_ready got=%b exp=0", cmd_ready);
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      total++;
      if ({top, depth, full, empty} !== stat_exp(0)) begin
         bad++;
         $display("FAIL wait_stat got=%h exp=%h",
                  {top, depth, full, empty}, stat_exp(0));
      end
      rst = 1'b1; #2; rst = 1'b0;
      model_reset();
      alu_ack = 1'b1; alu_result = 8'h99;
      @(posedge clk); #1;
      alu_ack = 1'b0;
      total++;
      if ({alu_req, cmd_ready, err_ovf, err_unf} !== 4'b0100) begin
         bad++;
         $display("FAIL abort_hs got=%b exp=0100",
                  {alu_req, cmd_ready, err_ovf, err_unf});
      end
      for (int s = 0; s < NS; s++) begin
         sel = 2'(s); #1;
         total++;
         if ({top, depth, full, empty} !== stat_exp(s)) begin
            bad++;
            $display("FAIL abort_stat k=%0d got=%h exp=%h", s,
                     {top, depth, full, empty}, stat_exp(s));
         end
      end
   endtask

   task automatic test_pop();
      bit acc;
      do_cmd(2'b01, 0, 8'h55, acc);
      do_cmd(2'b01, 0, 8'h56, acc);
      do_cmd(2'b10, 0, 8'h00, acc);
      sel = 2'd0; #1;
      total++;
      if ({top, depth, full, empty} !== stat_exp(0)) begin
         bad++;
         $display("FAIL pop_stat got=%h exp=%h",
                  {top, depth, full, empty}, stat_exp(0));
      end
      do_cmd(2'b10, 0, 8'h00, acc);
      do_cmd(2'b10, 0, 8'h00, acc);
      total++;
      if ({err_ovf, err_unf, depth} !== {m_ovf, m_unf, 4'(m_dep[0])}) begin
         bad++;
         $display("FAIL pop_empty got=%h exp=%h", {err_ovf, err_unf, depth},
                  {m_ovf, m_unf, 4'(m_dep[0])});
      end
   endtask

   task automatic test_back_to_back();
      bit   acc;
      ops_t e;
      int   s, c, q;
      for (int i = 0; i < 80; i++) begin
         c = $urandom_range(0, 3);
         s = $urandom_range(0, NS - 1);
         if (c == 3 && i % 3 != 0) c = 1;
         do_cmd(2'(c), s, 8'($urandom), acc);
         if (acc) begin
            wait_ops("rnd", e);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            do_ack(s, 8'($urandom));
         end
         q = $urandom_range(0, NS - 1);
         sel = 2'(q); #1;
         total++;
         if ({top, depth, full, empty} !== stat_exp(q)) begin
            bad++;
            $display("FAIL rnd_stat i=%0d k=%0d got=%h exp=%h", i, q,
                     {top, depth, full, empty}, stat_exp(q));
         end
      end
      total++;
      if ({err_ovf, err_unf} !== {m_ovf, m_unf}) begin
         bad++;
         $display("FAIL rnd_err got=%b exp=%b",
                  {err_ovf, err_unf}, {m_ovf, m_unf});
      end
   endtask

   initial begin
      test_reset();
      test_push();
      test_reduce();
      test_overflow();
      test_underflow();
      test_wait_alu();
      test_pop();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_operand_stack.md
ALU_OPERAND_STACK -- requirements
Module: alu_operand_stack

Interface
REQ-001 Parameter NSTACK, 4, number of independent operand stacks (k).
REQ-002 Parameter DEPTH, 8, entries per stack; power of two.
REQ-003 Parameter W, 8, data width; matches ALU operand width.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 cmd_valid  in  1  command offered this cycle.
REQ-008 cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
REQ-009 cmd  in  2  00 NOP, 01 PUSH, 10 POP, 11 REDUCE.
REQ-010 sel  in  log2(NSTACK)  stack index k for the command.
REQ-011 push_data  in  W  value for PUSH.
REQ-012 alu_req  out  1  operands presented to the ALU; held until alu_ack.
REQ-013 alu_a  out  W  top of stack k at REDUCE accept (pilhas[k][p]).
REQ-014 alu_b  out  W  entry below top (pilhas[k][p+1]).
REQ-015 alu_ack  in  1  ALU result valid.
REQ-016 alu_result  in  W  value pushed back on REDUCE completion.
REQ-017 top  out  W  current top of stack sel (combinational peek; 0 when empty).
REQ-018 depth  out  log2(DEPTH)+1  current entry count of stack sel.
REQ-019 full, empty  out  1 each  status of stack sel.
REQ-020 err_ovf, err_unf  out  1 each  sticky error flags; cleared only by reset.

Function
REQ-021 FSM states IDLE and WAIT_ALU; cmd_ready = 1 in IDLE, 0 in WAIT_ALU.
REQ-022 PUSH accepted, stack not full: write push_data at new top, depth+1, next cycle.
REQ-023 PUSH when full: no state change, err_ovf set next cycle.
REQ-024 POP accepted, depth>=1: depth-1, data discarded; POP when empty: no change, err_unf set.
REQ-025 REDUCE accepted with depth>=2: latch k, alu_a=top, alu_b=second; next cycle alu_req=1, state WAIT_ALU.
REQ-026 REDUCE with depth<2: no state change, err_unf set, remain IDLE, alu_req stays 0.
REQ-027 WAIT_ALU: alu_a, alu_b, latched k stable; sel, cmd, cmd_valid ignored.
REQ-028 alu_ack sampled only in WAIT_ALU; on ack: pop two, push alu_result (net depth-1), alu_req=0, return IDLE, same edge.
REQ-029 Minimum REDUCE latency: accept edge to result written = 2 edges (ack in first WAIT_ALU cycle); no timeout.
REQ-030 alu_ack while IDLE is ignored.
REQ-031 NOP and cmd_valid=0 cause no state change.
REQ-032 Stacks are independent; an operation on k never modifies any other stack.
REQ-033 Pointer arithmetic unsigned, no wrap: depth saturates at 0 and DEPTH by the rejection rules above.
REQ-034 Status outputs (top, depth, full, empty) reflect sel combinationally, including during WAIT_ALU.

Reset
REQ-035 On rst: state IDLE, all depths 0, alu_req=0, alu_a=alu_b=0, err_ovf=err_unf=0; storage contents not cleared.
REQ-036 rst asserted in WAIT_ALU aborts the REDUCE; a later alu_ack has no effect.
REQ-037 First command accepted on the first rising edge after rst deasserts.

Structure
REQ-038 Shared package holds W, cmd encoding (NOP/PUSH/POP/REDUCE) and state encoding (IDLE/WAIT_ALU).
REQ-039 One sub-module, stack_bank: NSTACK x DEPTH storage, per-stack depth counters, single write port, two read ports.
REQ-040 FSM, handshake and error logic live in alu_operand_stack.

Verification
REQ-041 Reset, PUSH 0x05 then 0x03 to k=1 -> depth(k=1)=2, top=0x03, depth(k=0)=0.
REQ-042 REDUCE k=1, ack after 3 cycles with 0x08 -> alu_a=0x03, alu_b=0x05 held 3 cycles, then depth=1, top=0x08.
REQ-043 PUSH 9 values to k=2 (DEPTH=8) -> 9th ignored, depth=8, full=1, err_ovf=1 from next cycle.
REQ-044 REDUCE on k=3 with depth=1 -> no alu_req, depth=1, err_unf=1, cmd_ready stays 1.
REQ-045 rst pulse during WAIT_ALU then alu_ack=1 -> alu_req=0, all depths 0, no write.
REQ-046 PUSH to k=0 offered during WAIT_ALU -> cmd_ready=0, depth(k=0) unchanged.
